// File: rtl/aes_pkg.sv
// Shared AES constants, state type and helpers for the key expander and cipher cores.
package aes_pkg;

   localparam int NB = 4;

   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] GF_POLY   = 8'h1b;

   // Legal key-length / round-count pairings
   localparam int NK_128 = 4;
   localparam int NR_128 = 10;
   localparam int NK_192 = 6;
   localparam int NR_192 = 12;
   localparam int NK_256 = 8;
   localparam int NR_256 = 14;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EXPAND,
      ST_DONE
   } kx_state_e;

   // Forward S-box, entry 0 first
   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8)
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward S-box, one byte. Shared with the cipher core.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expander_seq.sv
// Iterative AES key expansion: one 32-bit schedule word per clock through a
// single SubWord datapath. The schedule is held in a packed register array
// laid out exactly as the cipher/decipher cores consume it (w[0] at the MSBs).
module aes_key_expander_seq
   import aes_pkg::*;
#(
   parameter int NK = 4,
   parameter int NR = 10
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [32*NK-1:0]        key_in,
   output logic                    busy,
   output logic                    done,
   output logic                    keys_valid,
   output logic                    word_valid,
   output logic [5:0]              word_idx,
   output logic [31:0]             word_out,
   output logic [128*(NR+1)-1:0]   all_keys
);

   localparam int         NW    = NB * (NR + 1);
   localparam logic [5:0] NK6   = 6'(NK);
   localparam logic [5:0] LAST  = 6'(NW - 1);
   localparam logic [2:0] KMAX  = 3'(NK - 1);

   kx_state_e state, state_nxt;

   // Ascending packed range puts w[0] in the most significant word
   logic [0:NW-1][31:0] w;
   logic [5:0]          i;
   logic [2:0]          k;
   logic [7:0]          rcon;
   logic                kv;

   logic [31:0] prev, rot, sub_in, sub_out, temp, new_word;

   // Word datapath: pick RotWord or plain word into the shared SubWord, then mix in rcon
   always_comb begin
      prev     = w[i - 6'd1];
      rot      = {prev[23:0], prev[31:24]};
      sub_in   = (k == 3'd0) ? rot : prev;
      temp     = prev;
      if (k == 3'd0)
         temp = sub_out ^ {rcon, 24'h0};
      else if (NK == 8 && k == 3'd4)
         temp = sub_out;
      new_word = w[i - NK6] ^ temp;
   end

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte  (sub_in[8*b +: 8]),
         .out_byte (sub_out[8*b +: 8])
      );
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state and per-state outputs
   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      done       = 1'b0;
      word_valid = 1'b0;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_LOAD;
         ST_LOAD: begin
            busy      = 1'b1;
            state_nxt = ST_EXPAND;
         end
         ST_EXPAND: begin
            busy       = 1'b1;
            word_valid = 1'b1;
            if (i == LAST) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Schedule storage, word/round counters and rcon
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w    <= '0;
         i    <= '0;
         k    <= '0;
         rcon <= RCON_INIT;
         kv   <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               w[0 +: NK] <= key_in;
               i          <= NK6;
               k          <= '0;
               rcon       <= RCON_INIT;
               kv         <= 1'b0;
            end
            ST_EXPAND: begin
               w[i] <= new_word;
               i    <= i + 6'd1;
               k    <= (k == KMAX) ? 3'd0 : k + 3'd1;
               if (k == 3'd0) rcon <= xtime(rcon);
            end
            ST_DONE:  kv <= 1'b1;
            default:  ;
         endcase
      end
   end

   assign keys_valid = kv;
   assign word_idx   = word_valid ? i : 6'd0;
   assign word_out   = word_valid ? new_word : 32'h0;
   assign all_keys   = w;

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Directed bench for the sequential key expander: three instances (128/192/256)
// run side by side against published key-schedule words, plus reset, start
// re-pulse and an end-to-end cipher check on the produced round keys.
module tb_aes_key_expander_seq;
   import aes_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic start;

   logic [127:0]  key4;
   logic [191:0]  key6;
   logic [255:0]  key8;

   logic busy4, done4, kv4, wv4;  logic [5:0] wi4; logic [31:0] wo4; logic [1407:0] ak4;
   logic busy6, done6, kv6, wv6;  logic [5:0] wi6; logic [31:0] wo6; logic [1663:0] ak6;
   logic busy8, done8, kv8, wv8;  logic [5:0] wi8; logic [31:0] wo8; logic [1919:0] ak8;

   int checks   = 0;
   int failures = 0;
   int gcyc     = 0;
   int t0       = 0;
   int run_id   = 0;

   logic [31:0] wl4 [64];
   logic [31:0] wl6 [64];
   logic [31:0] wl8 [64];
   logic [7:0]  rl4 [64];
   int          st4 [64];
   int dc4 = 0, dc6 = 0, dc8 = 0;
   int da4 = 0, da6 = 0, da8 = 0;

   aes_key_expander_seq #(.NK(4), .NR(10)) dut4 (
      .clk(clk), .reset(reset), .start(start), .key_in(key4), .busy(busy4), .done(done4),
      .keys_valid(kv4), .word_valid(wv4), .word_idx(wi4), .word_out(wo4), .all_keys(ak4));

   aes_key_expander_seq #(.NK(6), .NR(12)) dut6 (
      .clk(clk), .reset(reset), .start(start), .key_in(key6), .busy(busy6), .done(done6),
      .keys_valid(kv6), .word_valid(wv6), .word_idx(wi6), .word_out(wo6), .all_keys(ak6));

   aes_key_expander_seq #(.NK(8), .NR(14)) dut8 (
      .clk(clk), .reset(reset), .start(start), .key_in(key8), .busy(busy8), .done(done8),
      .keys_valid(kv8), .word_valid(wv8), .word_idx(wi8), .word_out(wo8), .all_keys(ak8));

   always #5 clk = ~clk;

   // Cycle count; cycle n of a run is seen at negedge as gcyc == t0 + n
   always @(posedge clk) gcyc <= gcyc + 1;

   // Word / done monitors
   always @(negedge clk) begin
      if (wv4) begin
         wl4[wi4] <= wo4;
         rl4[wi4] <= dut4.rcon;
         st4[wi4] <= run_id;
      end
      if (wv6) wl6[wi6] <= wo6;
      if (wv8) wl8[wi8] <= wo8;
      if (done4) begin dc4 <= dc4 + 1; da4 <= gcyc - t0; end
      if (done6) begin dc6 <= dc6 + 1; da6 <= gcyc - t0; end
      if (done8) begin dc8 <= dc8 + 1; da8 <= gcyc - t0; end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
      end
   endtask

   task automatic kick();
      @(negedge clk);
      start = 1'b1;
      t0    = gcyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [7:0] m2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Reference AES-128 encryption using the expanded key bus as round keys
   function automatic logic [127:0] enc(input logic [127:0] pt, input logic [1407:0] rk);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] st;
      logic [7:0]   a0, a1, a2, a3;
      st = pt ^ rk[1407 -: 128];
      for (int r = 1; r <= 10; r++) begin
         for (int n = 0; n < 16; n++) s[n] = SBOX[st[127-8*n -: 8]];
         for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) t[j+4*c] = s[j+4*((c+j)%4)];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               t[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
               t[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
               t[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
               t[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
            end
         end
         for (int n = 0; n < 16; n++) st[127-8*n -: 8] = t[n];
         st = st ^ rk[1407-128*r -: 128];
      end
      return st;
   endfunction

   logic [7:0] rcon_exp [10];
   int         dsave;

   initial begin
      rcon_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      reset = 1'b1;
      start = 1'b0;
      key4  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      key6  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
      key8  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy",  128'(busy4), 128'(0));
      chk("rst_done",  128'(done4), 128'(0));
      chk("rst_kv",    128'(kv4),   128'(0));
      chk("rst_wv",    128'(wv4),   128'(0));
      chk("rst_keys",  ak8[1919 -: 128], 128'h0);
      chk("rst_rcon",  128'(dut4.rcon), 128'h01);
      reset = 1'b0;
      @(negedge clk);

      // Run 1: all three key sizes, start re-pulsed at cycles 5 and 30
      run_id = 1;
      kick();
      chk("ld_busy", 128'(busy4), 128'(1));
      chk("ld_wv",   128'(wv4),   128'(0));
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (24) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);

      chk("k128_w4",    128'(wl4[4]),  128'ha0fafe17);
      chk("k128_w43",   128'(wl4[43]), 128'hb6630ca6);
      chk("k128_done_at", 128'(da4),   128'(42));
      chk("k128_ndone", 128'(dc4),     128'(1));
      chk("k128_kv",    128'(kv4),     128'(1));
      chk("k128_busy",  128'(busy4),   128'(0));
      chk("k128_rk0",   ak4[1407 -: 128], 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("k128_rk10",  ak4[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      for (int m = 0; m < 10; m++) chk($sformatf("rcon_w%0d", 4*(m+1)), 128'(rl4[4*(m+1)]), 128'(rcon_exp[m]));
      chk("k192_w6",    128'(wl6[6]),  128'hfe0c91f7);
      chk("k192_w51",   128'(wl6[51]), 128'h01002202);
      chk("k192_done_at", 128'(da6),   128'(48));
      chk("k192_ndone", 128'(dc6),     128'(1));
      chk("k256_w8",    128'(wl8[8]),  128'h9ba35411);
      chk("k256_w12",   128'(wl8[12]), 128'ha8b09c1a);
      chk("k256_w59",   128'(wl8[59]), 128'h706c631e);
      chk("k256_done_at", 128'(da8),   128'(54));
      chk("k256_ndone", 128'(dc8),     128'(1));
      chk("k256_kv",    128'(kv8),     128'(1));

      // Run 2: reset at cycle 20 aborts without a done pulse
      run_id = 2;
      kick();
      repeat (19) @(negedge clk);
      dsave = dc4;
      reset = 1'b1;
      #1;
      chk("mrst_busy", 128'(busy4), 128'(0));
      chk("mrst_wv",   128'(wv4),   128'(0));
      chk("mrst_kv",   128'(kv4),   128'(0));
      chk("mrst_hi",   ak4[1407 -: 128], 128'h0);
      chk("mrst_lo",   ak4[127:0], 128'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      chk("mrst_nodone", 128'(dc4), 128'(dsave));
      chk("mrst_kv_after", 128'(kv4), 128'(0));

      // Run 3: fresh start after the aborted run
      run_id = 3;
      kick();
      repeat (60) @(negedge clk);
      chk("rerun_w43",   128'(wl4[43]), 128'hb6630ca6);
      chk("rerun_stamp", 128'(st4[43]), 128'(3));
      chk("rerun_ndone", 128'(dc4),     128'(dsave + 1));
      chk("rerun_kv",    128'(kv4),     128'(1));

      // Run 4: FIPS-197 C.1 key through a reference cipher
      key4   = 128'h000102030405060708090a0b0c0d0e0f;
      run_id = 4;
      kick();
      repeat (60) @(negedge clk);
      chk("sys_rk10", ak4[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("sys_ct", enc(128'h00112233445566778899aabbccddeeff, ak4),
          128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
